// File: rtl/or_reduce_seq_pkg.sv
// rtl/or_reduce_seq_pkg.sv - shared types for the bit-serial OR-reduction controller
package or_reduce_seq_pkg;

  // Controller states; S_IDLE doubles as the reset state
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/or_reduce_seq_or_gate.sv
// rtl/or_reduce_seq_or_gate.sv - 2-input OR gate shared as the accumulate datapath
module or_reduce_seq_or_gate (
  input  logic in0,
  input  logic in1,
  output logic y
);

  assign y = in0 | in1;

endmodule

// File: rtl/or_reduce_seq.sv
// rtl/or_reduce_seq.sv - bit-serial OR-reduction controller; optional early exit via OR_REDUCE_SEQ_EARLY_EXIT_EN
module or_reduce_seq
  import or_reduce_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic [CW-1:0]    cycles,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh;
  logic             acc;
  logic             acc_nxt;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             hit;

  // The only OR in the datapath: folds the current LSB into the accumulator
  or_reduce_seq_or_gate u_or_gate (
    .in0 (acc),
    .in1 (sh[0]),
    .y   (acc_nxt)
  );

  // cnt holds the number of bits already folded, so cnt==WIDTH-1 marks the final bit
  assign last_bit = (cnt == CW'(WIDTH - 1));

`ifdef OR_REDUCE_SEQ_EARLY_EXIT_EN
  // A set bit decides the result, so the scan can stop on it
  assign hit = sh[0];
`else
  assign hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, scan in RUN, hold in DONE until taken
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)          state_nxt = S_RUN;
      S_RUN:   if (last_bit || hit)   state_nxt = S_DONE;
      S_DONE:  if (out_ready)         state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state alone
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state == S_RUN) || (state == S_DONE);
  end

  assign result = acc;
  assign cycles = cnt;

  // Datapath: capture the word on accept, then shift one bit per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      acc <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sh  <= in_data;
            acc <= 1'b0;
            cnt <= '0;
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          sh  <= sh >> 1;
          cnt <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_or_reduce_seq.sv
// tb/tb_or_reduce_seq.sv - self-checking bench for or_reduce_seq (WIDTH=8), either OR_REDUCE_SEQ_EARLY_EXIT_EN build
module tb_or_reduce_seq;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);
`ifdef OR_REDUCE_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             result;
  logic [CW-1:0]    cycles;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  or_reduce_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cycles    (cycles),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               exp_result;
    int               exp_cycles;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: OR is "any bit set"; early exit stops on the first set bit
  function automatic int model_cycles(input logic [WIDTH-1:0] w);
    if (EE) begin
      for (int i = 0; i < WIDTH; i++) if (w[i]) return i + 1;
    end
    return WIDTH;
  endfunction

  function automatic int model_result(input logic [WIDTH-1:0] w);
    return (w != 0) ? 1 : 0;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge
  task automatic accept_word(input logic [WIDTH-1:0] w, input string tag);
    int k;
    in_valid = 1'b1;
    in_data  = w;
    k = 0;
    while (!in_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) check({tag, " accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
  endtask

  task automatic await_done(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check({tag, " done_timeout"}, 0, 1);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid_after_take"}, 32'(out_valid), 0);
    check({tag, " in_ready_after_take"}, 32'(in_ready), 1);
  endtask

  task automatic run_word(input logic [WIDTH-1:0] w, input int er, input int ec, input string tag);
    int lat;
    accept_word(w, tag);
    check({tag, " busy_run"}, 32'(busy), 1);
    check({tag, " in_ready_run"}, 32'(in_ready), 0);
    await_done(tag, lat);
    check({tag, " latency"}, lat, ec);
    check({tag, " result"}, 32'(result), er);
    check({tag, " cycles"}, 32'(cycles), ec);
    consume(tag);
  endtask

  initial begin
    vec_t vecs[6];
    logic [WIDTH-1:0] w;
    logic             r0;
    logic [CW-1:0]    c0;
    int               lat;

    vecs[0] = '{8'h00, 0, 8};
    vecs[1] = '{8'h80, 1, 8};
    vecs[2] = '{8'h04, 1, EE ? 3 : 8};
    vecs[3] = '{8'hFF, 1, EE ? 1 : 8};
    vecs[4] = '{8'h01, 1, EE ? 1 : 8};
    vecs[5] = '{8'h10, 1, EE ? 5 : 8};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 1);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset result", 32'(result), 0);
    check("reset cycles", 32'(cycles), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 6; i++)
      run_word(vecs[i].data, vecs[i].exp_result, vecs[i].exp_cycles, $sformatf("vec%0d", i));

    // Random words against the reference model
    for (int i = 0; i < 20; i++) begin
      w = WIDTH'($urandom);
      if (i % 4 == 0) w = w & WIDTH'($urandom);
      if (i % 5 == 0) w = '0;
      run_word(w, model_result(w), model_cycles(w), $sformatf("rand%0d", i));
    end

    // Back-to-back with in_valid held high, plus 5 cycles of backpressure in DONE
    accept_word(8'h00, "b2b0");
    in_valid = 1'b1;
    in_data  = 8'h10;
    await_done("b2b0", lat);
    check("b2b0 latency", lat, 8);
    r0 = result;
    c0 = cycles;
    check("b2b0 result", 32'(r0), 0);
    check("b2b0 cycles", 32'(c0), 8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d out_valid", i), 32'(out_valid), 1);
      check($sformatf("bp%0d result", i), 32'(result), 32'(r0));
      check($sformatf("bp%0d cycles", i), 32'(cycles), 32'(c0));
      check($sformatf("bp%0d in_ready", i), 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b handoff in_ready", 32'(in_ready), 1);
    check("b2b handoff busy", 32'(busy), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b1 accepted busy", 32'(busy), 1);
    await_done("b2b1", lat);
    check("b2b1 latency", lat, model_cycles(8'h10));
    check("b2b1 result", 32'(result), 1);
    check("b2b1 cycles", 32'(cycles), model_cycles(8'h10));
    consume("b2b1");

    // Asynchronous reset in the 4th RUN cycle
    accept_word(8'h00, "rstmid");
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rstmid in_ready", 32'(in_ready), 1);
    check("rstmid out_valid", 32'(out_valid), 0);
    check("rstmid busy", 32'(busy), 0);
    check("rstmid cycles", 32'(cycles), 0);
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst idle", 32'(in_ready), 1);
    run_word(8'h01, 1, model_cycles(8'h01), "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
